// File: rtl/mmss_pkg.sv
// mmss_pkg: shared state encoding, digit geometry and BCD field layout for the mm:ss timer
package mmss_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] SEC_TENS_MAX = 4'd5;
  localparam logic [DIGIT_W-1:0] SEC_ONES_MAX = 4'd9;
  localparam int SEC_ONES_LSB = 0;
  localparam int SEC_TENS_LSB = 4;
  localparam int MIN_ONES_LSB = 8;
  localparam int MIN_TENS_LSB = 12;
  function automatic logic [DIGIT_W-1:0] field(input logic [15:0] v, input int lsb);
    return v[lsb +: DIGIT_W];
  endfunction
endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one registered BCD digit counting 0..MAX up or down with carry/borrow out
module bcd_digit import mmss_pkg::*; #(
  parameter int MAX = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               ld,
  input  logic [DIGIT_W-1:0] d,
  input  logic               en,
  input  logic               up,
  output logic [DIGIT_W-1:0] q,
  output logic               co
);
  localparam logic [DIGIT_W-1:0] TOP = DIGIT_W'(MAX);
  assign co = en && (up ? q == TOP : q == '0);
  // clear beats load beats count; count rolls over at either end of 0..MAX
  always_ff @(posedge clk)
    if (rst || clr) q <= '0;
    else if (ld) q <= d;
    else if (en) q <= up ? (q == TOP ? '0 : q + 1'b1) : (q == '0 ? TOP : q - 1'b1);
endmodule

// File: rtl/mmss_timer.sv
// mmss_timer: MM:SS BCD up/down timer with start/stop/clear/load command FSM
module mmss_timer import mmss_pkg::*; #(
  parameter int MAX_MIN = 59
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_en,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        load,
  input  logic        up_dn,
  input  logic [15:0] load_bcd,
  output logic [15:0] time_bcd,
  output logic        running,
  output logic        done,
  output logic        wrap,
  output logic        load_err
);
  localparam logic [15:0] LAST = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10), 8'h59};
  state_t state, nxt;
  logic [3:0] en, co;
  logic [7:0] ld_min;
  logic count_tick, wrap_now, done_now, load_ok, load_take, unused_carry;
  assign ld_min = 8'(field(load_bcd, MIN_TENS_LSB)) * 8'd10 + 8'(field(load_bcd, MIN_ONES_LSB));
  assign load_ok = field(load_bcd, SEC_TENS_LSB) <= SEC_TENS_MAX
                && field(load_bcd, SEC_ONES_LSB) <= SEC_ONES_MAX
                && field(load_bcd, MIN_ONES_LSB) <= SEC_ONES_MAX
                && field(load_bcd, MIN_TENS_LSB) <= SEC_ONES_MAX
                && ld_min <= 8'(MAX_MIN);
  assign load_take = load && !clear && load_ok;
  assign count_tick = state == RUN && tick_en && !clear && !load && !stop;
  assign wrap_now = count_tick && up_dn && time_bcd == LAST;
  assign done_now = count_tick && !up_dn && time_bcd == 16'h0001;
  assign en = {co[2:0], count_tick && !wrap_now};
  assign unused_carry = co[3];
  for (genvar i = 0; i < 4; i++) begin : g_digit
    bcd_digit #(
      .MAX(i == 3 ? MAX_MIN / 10 : i == 1 ? int'(SEC_TENS_MAX) : int'(SEC_ONES_MAX))
    ) u_digit (
      .clk(clk),
      .rst(rst),
      .clr(clear || wrap_now),
      .ld(load_take),
      .d(load_bcd[i*DIGIT_W +: DIGIT_W]),
      .en(en[i]),
      .up(up_dn),
      .q(time_bcd[i*DIGIT_W +: DIGIT_W]),
      .co(co[i])
    );
  end
  // next state by command priority clear > load > stop > start, then RUN progress
  always_comb begin
    nxt = state;
    if (clear) nxt = IDLE;
    else if (load) nxt = load_ok ? IDLE : state;
    else if (stop) nxt = state == RUN ? PAUSE : state;
    else if (state == RUN) nxt = done_now ? DONE : RUN;
    else if (start && (up_dn || time_bcd != '0)) nxt = RUN;
  end
  // state and registered status pulses; load_err self-suppresses so it never lasts two cycles
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      running <= 1'b0;
      done <= 1'b0;
      wrap <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state <= nxt;
      running <= nxt == RUN;
      done <= done_now;
      wrap <= wrap_now;
      load_err <= load && !clear && !load_ok && !load_err;
    end
endmodule
